// File: rtl/fifo_pkg.sv
`default_nettype none
// =====================================================================
// Module   : fifo_pkg
// Purpose  : Shared state encoding and default sizing for the read packer.
// Revision : 1.0 - initial release
// =====================================================================
package fifo_pkg;

    localparam int c_DATA_WIDTH_DEF  = 8;
    localparam int c_PACK_FACTOR_DEF = 4;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_read_packer.sv
`default_nettype none
// =====================================================================
// Module   : fifo_read_packer
// Purpose  : Reads FIFO byte lanes and packs them into wide output words.
// Revision : 1.0 - initial release
// =====================================================================
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH_DEF,
    parameter int PACK_FACTOR = c_PACK_FACTOR_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              fifo_empty,
    input  logic [DATA_WIDTH-1:0]             fifo_dout,
    output logic                              fifo_read,
    input  logic                              flush,
    output logic [DATA_WIDTH*PACK_FACTOR-1:0] m_data,
    output logic [PACK_FACTOR-1:0]            m_keep,
    output logic                              m_valid,
    input  logic                              m_ready
);

    localparam int              CNT_W  = $clog2(PACK_FACTOR + 1);
    localparam logic [CNT_W:0]  c_PF   = (CNT_W + 1)'(PACK_FACTOR);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PACK_FACTOR - 1);

    state_t                            r_state;
    logic [CNT_W-1:0]                  r_cnt;
    logic                              r_inflight;
    logic                              r_flush_pend;
    logic [DATA_WIDTH*PACK_FACTOR-1:0] r_data;
    logic [PACK_FACTOR-1:0]            r_keep;
    logic                              r_valid;

    logic                              w_fill;
    logic [CNT_W:0]                    w_occupancy;
    logic [PACK_FACTOR-1:0]            w_lane_sel;
    logic                              w_last_lane;
    logic                              w_flush_take;

    // Occupancy counts the lane whose data is still on its way back from the FIFO.
    assign w_fill       = (r_state == ST_FILL);
    assign w_occupancy  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_inflight};
    assign fifo_read    = !reset && w_fill && !fifo_empty
                          && (w_occupancy < c_PF) && !r_flush_pend;
    assign w_lane_sel   = PACK_FACTOR'(1) << r_cnt;
    assign w_last_lane  = r_inflight && (r_cnt == c_LAST);
    assign w_flush_take = flush && (w_occupancy != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_FILL;
            r_cnt        <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_data       <= '0;
            r_keep       <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_inflight <= fifo_read;
            case (r_state)
                ST_FILL: begin
                    if (r_inflight) begin
                        for (int i = 0; i < PACK_FACTOR; i++) begin
                            if (w_lane_sel[i]) begin
                                r_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
                            end
                        end
                        r_keep <= r_keep | w_lane_sel;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                    // A pending flush blocks new reads, so any capture this edge is the last one.
                    if (w_last_lane || r_flush_pend) begin
                        r_state      <= ST_HOLD;
                        r_valid      <= 1'b1;
                        r_flush_pend <= 1'b0;
                    end else if (w_flush_take) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                        r_data  <= '0;
                        r_keep  <= '0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign m_data  = r_data;
    assign m_keep  = r_keep;
    assign m_valid = r_valid;

endmodule
`default_nettype wire
